// File: rtl/i2s_sample_receiver.sv
// i2s_sample_receiver: slave I2S deserializer on the system clock; oversamples
// BCLK/LRCK/SDATA and emits paired 24-bit left/right samples.
module i2s_sample_receiver #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              sample_valid,
  output logic              frame_err
);
  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;
  state_t r_state, w_next;
  logic [2:0] r_bclk_sync;
  logic [1:0] r_lr_sync, r_sd_sync;
  logic r_ws_prev, r_ws_vld, r_slot_right, r_hold_vld;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [DATA_W-1:0] r_shreg, r_left_hold;
  logic w_bclk_rise, w_ws, w_sd, w_boundary;
  logic w_clear, w_shift, w_done, w_trunc;
  logic [DATA_W-1:0] w_word;
  assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_ws        = r_lr_sync[1];
  assign w_sd        = r_sd_sync[1];
  // the first edge after reset has no predecessor, so it can never be a boundary
  assign w_boundary  = w_bclk_rise & r_ws_vld & (w_ws != r_ws_prev);
  assign w_word      = {r_shreg[DATA_W-2:0], w_sd};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_shift = 1'b0;
    w_done  = 1'b0;
    w_trunc = 1'b0;
    case (r_state)
      IDLE:  w_next = (w_boundary && !w_ws) ? SKIP : IDLE;
      SKIP: begin
        w_clear = 1'b1;
        w_next  = SHIFT;
      end
      SHIFT:
        if (w_boundary) begin
          w_trunc = 1'b1;
          w_next  = SKIP;
        end else if (w_bclk_rise) begin
          w_shift = 1'b1;
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_done = 1'b1;
            w_next = WAIT;
          end
        end
      WAIT:  w_next = w_boundary ? SKIP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bclk_sync  <= '0;
      r_lr_sync    <= '0;
      r_sd_sync    <= '0;
      r_ws_prev    <= 1'b0;
      r_ws_vld     <= 1'b0;
      r_slot_right <= 1'b0;
      r_hold_vld   <= 1'b0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_left_hold  <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      r_bclk_sync  <= {r_bclk_sync[1:0], i2s_bclk};
      r_lr_sync    <= {r_lr_sync[0], i2s_lrclk};
      r_sd_sync    <= {r_sd_sync[0], i2s_sdata};
      sample_valid <= 1'b0;
      frame_err    <= w_trunc;
      if (w_bclk_rise) begin
        r_ws_prev <= w_ws;
        r_ws_vld  <= 1'b1;
      end
      // r_ws_prev already holds the new slot's word select here
      if (w_clear) begin
        r_bit_cnt    <= '0;
        r_shreg      <= '0;
        r_slot_right <= r_ws_prev;
      end
      if (w_shift) begin
        r_shreg   <= w_word;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_done && !r_slot_right) begin
        r_left_hold <= w_word;
        r_hold_vld  <= 1'b1;
      end
      if (w_done && r_slot_right) begin
        r_hold_vld <= 1'b0;
        if (r_hold_vld) begin
          left_out     <= r_left_hold;
          right_out    <= w_word;
          sample_valid <= 1'b1;
        end
      end
      if (w_trunc) r_hold_vld <= 1'b0;
    end
endmodule

// File: tb/tb_i2s_sample_receiver.sv
// tb_i2s_sample_receiver: table vectors, hand corner sequences and random slot
// streams checked against a slot-level model of the I2S receive rules.
module tb_i2s_sample_receiver;
  localparam int DW = 24;
  logic clk = 1'b0, rst_n = 1'b0, bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
  logic [DW-1:0] left_out, right_out;
  logic sample_valid, frame_err;
  i2s_sample_receiver #(.DATA_W(24), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .left_out(left_out), .right_out(right_out), .sample_valid(sample_valid), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  int n_pass = 0, n_tot = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tot++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask
  int cyc = 0, vcnt = 0, ecnt = 0, hold_bad = 0;
  logic [DW-1:0] ql[$], qr[$], pl = '0, pr = '0;
  int qt[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      vcnt <= 0;
      ecnt <= 0;
      hold_bad <= 0;
      ql.delete();
      qr.delete();
      qt.delete();
    end else begin
      if (sample_valid) begin
        vcnt <= vcnt + 1;
        ql.push_back(left_out);
        qr.push_back(right_out);
        qt.push_back(cyc);
      end else if (left_out !== pl || right_out !== pr) hold_bad <= hold_bad + 1;
      if (frame_err) ecnt <= ecnt + 1;
    end
    pl <= left_out;
    pr <= right_out;
  end
  typedef struct {bit ws; int len; logic [DW-1:0] d;} slot_t;
  slot_t sl[$];
  logic [DW-1:0] el[$], er[$];
  int eerr;
  task automatic add(input bit ws, input int len, input logic [DW-1:0] d);
    slot_t s;
    s.ws = ws;
    s.len = len;
    s.d = d;
    sl.push_back(s);
  endtask
  // Slot-level rules: arm on the first 1->0 word-select change, a slot shorter
  // than DW+1 BCLKs is truncated, and a right word pairs only with the left word
  // completed in the slot just before it.
  function automatic void model();
    bit armed = 0, hv = 0;
    logic [DW-1:0] hold = '0;
    el.delete();
    er.delete();
    eerr = 0;
    for (int i = 1; i < sl.size(); i++) begin
      if (sl[i].ws == sl[i-1].ws) continue;
      if (!armed && !sl[i].ws) armed = 1;
      if (!armed) continue;
      if (sl[i].len < DW + 1) begin
        if (i + 1 < sl.size()) begin
          eerr++;
          hv = 0;
        end
      end else if (!sl[i].ws) begin
        hold = sl[i].d;
        hv = 1;
      end else if (hv) begin
        el.push_back(hold);
        er.push_back(sl[i].d);
        hv = 0;
      end
    end
  endfunction
  task automatic send_bit(input bit ws, input bit b, input int h);
    @(negedge clk);
    bclk = 1'b0;
    lrclk = ws;
    sdata = b;
    repeat (h - 1) @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    repeat (h - 1) @(negedge clk);
  endtask
  task automatic send_stream(input int h);
    foreach (sl[i])
      for (int k = 0; k < sl[i].len; k++) begin
        bit b;
        b = (k >= 1 && k <= DW) ? sl[i].d[DW-k] : 1'($urandom);
        send_bit(sl[i].ws, b, h);
      end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bclk = 1'b0;
    lrclk = sl[0].ws;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic compare(input string nm);
    chk({nm, " pair count"}, vcnt, el.size());
    chk({nm, " frame_err count"}, ecnt, eerr);
    chk({nm, " hold"}, hold_bad, 0);
    for (int i = 0; i < ql.size() && i < el.size(); i++) begin
      chk($sformatf("%s left[%0d]", nm, i), ql[i], el[i]);
      chk($sformatf("%s right[%0d]", nm, i), qr[i], er[i]);
    end
  endtask
  task automatic run(input string nm, input int h);
    do_reset();
    model();
    send_stream(h);
    repeat (20) @(negedge clk);
    compare(nm);
  endtask
  typedef struct {logic [DW-1:0] l, r; int h; logic [DW-1:0] xl, xr; logic [15:0] xl16, xr16;} vec_t;
  vec_t tbl[4];
  initial begin
    tbl[0] = '{24'h01E240, 24'hF6040F, 4, 24'h01E240, 24'hF6040F, 16'h01E2, 16'hF604};
    tbl[1] = '{24'h7FFFFF, 24'h800000, 3, 24'h7FFFFF, 24'h800000, 16'h7FFF, 16'h8000};
    tbl[2] = '{24'h800000, 24'h7FFFFF, 3, 24'h800000, 24'h7FFFFF, 16'h8000, 16'h7FFF};
    tbl[3] = '{24'hA5A5A5, 24'h000001, 5, 24'hA5A5A5, 24'h000001, 16'hA5A5, 16'h0000};
    repeat (3) @(negedge clk);
    chk("reset left_out", left_out, 0);
    chk("reset right_out", right_out, 0);
    chk("reset sample_valid", sample_valid, 0);
    chk("reset frame_err", frame_err, 0);
    foreach (tbl[i]) begin
      sl.delete();
      add(1, 32, 24'(($urandom)));
      add(0, 32, tbl[i].l);
      add(1, 32, tbl[i].r);
      add(0, 32, 24'($urandom));
      do_reset();
      send_stream(tbl[i].h);
      repeat (20) @(negedge clk);
      chk($sformatf("vec%0d valid count", i), vcnt, 1);
      chk($sformatf("vec%0d frame_err count", i), ecnt, 0);
      chk($sformatf("vec%0d left_out", i), left_out, tbl[i].xl);
      chk($sformatf("vec%0d right_out", i), right_out, tbl[i].xr);
      chk($sformatf("vec%0d left16", i), left_out[23:8], tbl[i].xl16);
      chk($sformatf("vec%0d right16", i), right_out[23:8], tbl[i].xr16);
    end
    sl.delete();
    add(0, 32, 24'h111111);
    add(1, 32, 24'h222222);
    add(0, 32, 24'h333333);
    add(1, 32, 24'h444444);
    add(0, 32, 24'h555555);
    rst_n = 1'b0;
    model();
    fork
      send_stream(4);
      begin
        repeat (150) @(negedge clk);
        chk("in-reset left_out", left_out, 0);
        chk("in-reset right_out", right_out, 0);
        chk("in-reset sample_valid", sample_valid, 0);
        rst_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    compare("reset mid-frame");
    sl.delete();
    add(1, 32, 24'h0BAD00);
    add(0, 32, 24'h123456);
    add(1, 32, 24'h654321);
    add(0, 20, 24'hDEAD00);
    add(1, 32, 24'hBEEF00);
    add(0, 32, 24'h0F0F0F);
    add(1, 32, 24'hF0F0F0);
    add(0, 32, 24'h000000);
    run("truncated left", 4);
    chk("truncated frame_err once", ecnt, 1);
    sl.delete();
    add(1, 32, 24'h0);
    for (int f = 0; f < 3; f++) begin
      add(0, 32, 24'(24'h100000 * (f + 1) + 24'h000ABC));
      add(1, 32, 24'(24'hE00000 - 24'h010000 * f));
    end
    add(0, 32, 24'h0);
    run("hold h4", 4);
    chk("hold pulse count", vcnt, 3);
    if (qt.size() == 3) begin
      chk("hold spacing 0-1", qt[1] - qt[0], 512);
      chk("hold spacing 1-2", qt[2] - qt[1], 512);
    end
    sl.delete();
    add(1, 32, 24'h0);
    for (int f = 0; f < 3; f++) begin
      add(0, 32, (f % 2 == 0) ? 24'h7FFFFF : 24'h800000);
      add(1, 32, (f % 2 == 0) ? 24'h800000 : 24'h7FFFFF);
    end
    add(0, 32, 24'h0);
    run("extremes h3", 3);
    chk("extremes pulse count", vcnt, 3);
    if (qt.size() == 3) chk("extremes spacing", qt[2] - qt[1], 384);
    for (int s = 0; s < 6; s++) begin
      bit ws;
      int n;
      sl.delete();
      ws = 1'($urandom);
      n = $urandom_range(8, 12);
      for (int i = 0; i < n; i++) begin
        add(ws, ($urandom_range(0, 4) == 0) ? $urandom_range(8, 24) : $urandom_range(25, 40), 24'($urandom));
        ws = ~ws;
      end
      run($sformatf("random%0d", s), $urandom_range(3, 5));
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
